// File: rtl/rsa_reader_if.sv
// Host-read and stream bus of the RSA result reader.
// The core-side result strobe is carried here too, so the reader has a single bus port.
interface rsa_reader_if #(
  parameter int unsigned NBYTES = 32,
  parameter int unsigned AW     = 5
);
  logic                  res_valid;
  logic [8*NBYTES-1:0]   res_data;
  logic                  oe;
  logic [1:0]            reg_sel;
  logic [AW-1:0]         addr;
  logic [7:0]            data_o;
  logic                  rd_valid;
  logic                  stream_start;
  logic                  stream_ready;
  logic                  stream_valid;
  logic [7:0]            stream_data;
  logic                  stream_last;
  logic                  result_full;
  logic                  overrun;

  modport master (
    output res_valid, res_data, oe, reg_sel, addr, stream_start, stream_ready,
    input  data_o, rd_valid, stream_valid, stream_data, stream_last, result_full, overrun
  );

  modport slave (
    input  res_valid, res_data, oe, reg_sel, addr, stream_start, stream_ready,
    output data_o, rd_valid, stream_valid, stream_data, stream_last, result_full, overrun
  );
endinterface

// File: rtl/rsa_reader.sv
// Captures the final exponentiation result and exposes it to a byte-wide host
// read port and a ready/valid byte stream.
module rsa_reader #(
  parameter int unsigned NBYTES = 32,
  parameter int unsigned AW     = 5
) (
  input logic         clk,
  input logic         reset,
  rsa_reader_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoaded, StStream} state_e;

  localparam logic [AW-1:0] LastIdx = AW'(NBYTES - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [7:0]    buf_q [NBYTES];
  logic [7:0]    data_q;
  logic          rd_valid_q;
  logic          overrun_q;

  logic          host_rd;
  logic          rd_clear;
  logic          capture;
  logic          handshake;
  logic          stream_valid;
  logic          stream_last;
  logic [7:0]    stream_data;
  logic          result_full;

  assign host_rd   = ~bus.oe;
  assign rd_clear  = host_rd && (bus.reg_sel == 2'd0) && (bus.addr == LastIdx);
  // A result arriving mid-stream is dropped so the dump stays self-consistent.
  assign capture   = bus.res_valid && (state_q != StStream);
  assign handshake = (state_q == StStream) && bus.stream_ready;

  // Buffer deliberately has no reset: contents survive a reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        buf_q[i] <= bus.res_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.res_valid) state_d = StLoaded;
      end
      StLoaded: begin
        // A same-cycle result beats read-to-clear.
        if (bus.stream_start) begin
          state_d = StStream;
          cnt_d   = '0;
        end else if (rd_clear && !bus.res_valid) begin
          state_d = StIdle;
        end
      end
      StStream: begin
        if (handshake) begin
          if (cnt_q == LastIdx) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stream_valid = 1'b0;
    stream_last  = 1'b0;
    stream_data  = 8'h00;
    result_full  = (state_q != StIdle);
    if (state_q == StStream) begin
      stream_valid = 1'b1;
      stream_last  = (cnt_q == LastIdx);
      stream_data  = buf_q[cnt_q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q     <= 8'h00;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rd_valid_q <= host_rd;
      if (host_rd) begin
        data_q <= (bus.reg_sel == 2'd0) ? buf_q[bus.addr] : 8'h00;
      end
      if (bus.res_valid && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.data_o       = data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.stream_valid = stream_valid;
  assign bus.stream_data  = stream_data;
  assign bus.stream_last  = stream_last;
  assign bus.result_full  = result_full;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_rsa_reader.sv
// Directed-plus-random bench for rsa_reader: result capture, host reads,
// streaming with stalls, overrun and asynchronous reset behaviour.
module tb_rsa_reader;
  localparam int unsigned NB  = 32;
  localparam int unsigned AWL = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rsa_reader_if #(.NBYTES(NB), .AW(AWL)) bus ();

  rsa_reader #(.NBYTES(NB), .AW(AWL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mbuf [NB];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8*NB-1:0] rand_word();
    logic [8*NB-1:0] w;
    for (int i = 0; i < NB; i++) w[8*i +: 8] = 8'($urandom);
    return w;
  endfunction

  // Capture while not streaming: the model buffer takes the new word.
  task automatic load(input logic [8*NB-1:0] w);
    bus.res_data  = w;
    bus.res_valid = 1'b1;
    tick();
    bus.res_valid = 1'b0;
    for (int i = 0; i < NB; i++) mbuf[i] = w[8*i +: 8];
  endtask

  task automatic host_read(input logic [1:0] sel, input logic [AWL-1:0] a);
    bus.oe      = 1'b0;
    bus.reg_sel = sel;
    bus.addr    = a;
    tick();
    bus.oe      = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: random ready.
  task automatic run_stream(input int mode, input int inject_at, input int read_at);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int lasts, last_pos, cyc;
    bit hold_chk, pend_read, injected, rdy;
    logic [7:0] prev_d;
    logic prev_l;
    lasts = 0; last_pos = -1; cyc = 0;
    hold_chk = 0; pend_read = 0; injected = 0;
    prev_d = 8'h00; prev_l = 1'b0;
    for (int i = 0; i < NB; i++) exp_q.push_back(mbuf[i]);
    bus.stream_start = 1'b1;
    tick();
    bus.stream_start = 1'b0;
    check("stream_enter", bus.stream_valid, 1);
    while (got_q.size() < NB && cyc < 400) begin
      if (pend_read) begin
        check("rd_in_stream_data", bus.data_o, mbuf[NB-1]);
        check("rd_in_stream_valid", bus.rd_valid, 1);
        bus.oe = 1'b1;
        pend_read = 0;
      end
      if (hold_chk) begin
        check("stall_data", bus.stream_data, prev_d);
        check("stall_last", bus.stream_last, prev_l);
        hold_chk = 0;
      end
      if (!bus.stream_valid) begin
        check("stream_valid_drop", bus.stream_valid, 1);
        break;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom);
      endcase
      bus.stream_ready = rdy;
      if (inject_at >= 0 && got_q.size() == inject_at && !injected) begin
        bus.res_data  = rand_word();
        bus.res_valid = 1'b1;
        injected = 1;
      end
      if (cyc == read_at) begin
        bus.oe      = 1'b0;
        bus.reg_sel = 2'd0;
        bus.addr    = AWL'(NB - 1);
        pend_read   = 1;
      end
      if (rdy) begin
        got_q.push_back(bus.stream_data);
        if (bus.stream_last) begin
          lasts++;
          last_pos = got_q.size() - 1;
        end
      end else begin
        hold_chk = 1;
        prev_d = bus.stream_data;
        prev_l = bus.stream_last;
      end
      tick();
      bus.res_valid = 1'b0;
      cyc++;
    end
    if (pend_read) begin
      check("rd_in_stream_data", bus.data_o, mbuf[NB-1]);
      bus.oe = 1'b1;
    end
    bus.stream_ready = 1'b0;
    check("stream_count", got_q.size(), NB);
    check("stream_last_count", lasts, 1);
    check("stream_last_pos", last_pos, NB - 1);
    for (int i = 0; i < got_q.size() && i < NB; i++) check("stream_byte", got_q[i], exp_q[i]);
    check("stream_done_valid", bus.stream_valid, 0);
    check("stream_done_last", bus.stream_last, 0);
    check("stream_done_full", bus.result_full, 0);
  endtask

  initial begin
    logic [8*NB-1:0] w, e;
    int cnt, guard;
    bus.res_valid = 1'b0; bus.res_data = '0; bus.oe = 1'b1; bus.reg_sel = 2'd0;
    bus.addr = '0; bus.stream_start = 1'b0; bus.stream_ready = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_data_o", bus.data_o, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_stream_valid", bus.stream_valid, 0);
    check("rst_stream_last", bus.stream_last, 0);
    check("rst_stream_data", bus.stream_data, 0);
    check("rst_result_full", bus.result_full, 0);
    check("rst_overrun", bus.overrun, 0);
    tick();
    reset = 1'b1;
    tick();

    // Read in IDLE and stream_start in IDLE are harmless.
    host_read(2'd0, AWL'(NB - 1));
    check("idle_rd_valid", bus.rd_valid, 1);
    check("idle_full", bus.result_full, 0);
    bus.stream_start = 1'b1;
    tick();
    bus.stream_start = 1'b0;
    check("idle_start_ignored", bus.stream_valid, 0);

    // Byte i = i, then reserved read and back-to-back reads 0, 5, 31.
    for (int i = 0; i < NB; i++) w[8*i +: 8] = 8'(i);
    load(w);
    check("load_full", bus.result_full, 1);
    check("load_overrun", bus.overrun, 0);
    host_read(2'd1, AWL'(NB - 1));
    check("resv_data", bus.data_o, 8'h00);
    check("resv_rd_valid", bus.rd_valid, 1);
    check("resv_keeps_full", bus.result_full, 1);
    bus.oe = 1'b0; bus.reg_sel = 2'd0; bus.addr = AWL'(0);
    tick();
    check("rd0_data", bus.data_o, 8'h00);
    check("rd0_valid", bus.rd_valid, 1);
    bus.addr = AWL'(5);
    tick();
    check("rd5_data", bus.data_o, 8'h05);
    check("rd5_valid", bus.rd_valid, 1);
    check("rd5_full", bus.result_full, 1);
    bus.addr = AWL'(31);
    tick();
    check("rd31_data", bus.data_o, 8'h1F);
    check("rd31_clears_full", bus.result_full, 0);
    bus.oe = 1'b1;
    tick();
    check("oe_high_rd_valid", bus.rd_valid, 0);
    check("oe_high_hold", bus.data_o, 8'h1F);

    // Streams: full rate with a mid-stream read, 1-0-0-1 stall pattern, random ready.
    load(w);
    run_stream(0, -1, 5);
    load(rand_word());
    run_stream(1, -1, -1);
    load(rand_word());
    run_stream(2, -1, -1);

    // Overrun in LOADED overwrites; overrun in STREAM leaves the dump intact.
    do_reset();
    check("ovr_after_reset", bus.overrun, 0);
    load(rand_word());
    check("ovr_first_load", bus.overrun, 0);
    e = rand_word();
    load(e);
    check("ovr_loaded", bus.overrun, 1);
    check("ovr_loaded_full", bus.result_full, 1);
    host_read(2'd0, AWL'(7));
    check("ovr_overwritten", bus.data_o, e[8*7 +: 8]);
    run_stream(0, 3, -1);
    check("ovr_stream", bus.overrun, 1);

    // Result arriving with the read-to-clear wins; old byte returned.
    do_reset();
    load(rand_word());
    e = rand_word();
    bus.oe = 1'b0; bus.reg_sel = 2'd0; bus.addr = AWL'(NB - 1);
    bus.res_data = e; bus.res_valid = 1'b1;
    tick();
    bus.oe = 1'b1; bus.res_valid = 1'b0;
    check("race_old_byte", bus.data_o, mbuf[NB-1]);
    check("race_full", bus.result_full, 1);
    check("race_overrun", bus.overrun, 1);
    for (int i = 0; i < NB; i++) mbuf[i] = e[8*i +: 8];
    host_read(2'd0, AWL'(NB - 1));
    check("race_new_byte", bus.data_o, mbuf[NB-1]);
    check("race_was_loaded", bus.result_full, 0);

    // Reset at byte 10 of a stream.
    load(rand_word());
    bus.stream_start = 1'b1;
    tick();
    bus.stream_start = 1'b0;
    bus.stream_ready = 1'b1;
    cnt = 0; guard = 0;
    while (cnt < 10 && guard < 100) begin
      if (bus.stream_valid) cnt++;
      tick();
      guard++;
    end
    check("midrst_reached", cnt, 10);
    check("midrst_byte10", bus.stream_data, mbuf[10]);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", bus.stream_valid, 0);
    check("midrst_last", bus.stream_last, 0);
    check("midrst_sdata", bus.stream_data, 0);
    check("midrst_data_o", bus.data_o, 0);
    check("midrst_rd_valid", bus.rd_valid, 0);
    check("midrst_full", bus.result_full, 0);
    check("midrst_overrun", bus.overrun, 0);
    tick();
    reset = 1'b1;
    bus.stream_start = 1'b1;
    tick();
    bus.stream_start = 1'b0;
    tick();
    check("post_rst_start_ignored", bus.stream_valid, 0);
    check("post_rst_full", bus.result_full, 0);
    bus.stream_ready = 1'b0;
    host_read(2'd0, AWL'(4));
    check("post_rst_buf_kept", bus.data_o, mbuf[4]);
    check("post_rst_read_full", bus.result_full, 0);
    host_read(2'd2, AWL'(4));
    check("post_rst_sel2", bus.data_o, 8'h00);
    check("post_rst_sel2_valid", bus.rd_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
